// File: rtl/traffic_pkg.sv
// traffic_pkg: shared states, light bit indices and patterns for the intersection controller.
//   Light vector ordering is {Rm,Ym,Gm,Rs,Ys,Gs,W}; approach 0 = main, 1 = side.
package traffic_pkg;

    typedef enum logic [2:0] {PASS, CLEAR, ALLRED, SERVE, RECOVER} state_e;

    localparam int RM = 6;
    localparam int YM = 5;
    localparam int GM = 4;
    localparam int RS = 3;
    localparam int YS = 2;
    localparam int GS = 1;
    localparam int W  = 0;

    localparam logic [6:0] ALL_RED = 7'b1001000;

    // One approach green (or yellow), the other approach red, walk off.
    function automatic logic [6:0] show(input logic side, input logic yellow);
        logic [6:0] l;
        l = '0;
        l[side ? RM : RS] = 1'b1;
        l[side ? (yellow ? YS : GS) : (yellow ? YM : GM)] = 1'b1;
        return l;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// tick_counter: saturating down-counter of enable ticks with a zero flag.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   load_i           : load load_value_i (wins over enable_i)
//   load_value_i     : value loaded on state entry
//   enable_i         : one-cycle tick; decrements while non-zero
//   zero_o           : counter reads 0
module tick_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             enable_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_value_i;
        else if (enable_i && cnt_q != '0)
            cnt_q <= cnt_q - WIDTH'(1);
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/preempt_controller.sv
// preempt_controller: emergency-vehicle preemption sequencer between light FSM and LED driver.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   enable_i           : 1 Hz tick
//   preempt_req_i[1:0] : level requests, [0]=main, [1]=side
//   lights_i[6:0]      : FSM lights {Rm,Ym,Gm,Rs,Ys,Gs,W}
//   lights_o[6:0]      : registered lights to the LED driver
//   fsm_hold_o         : freezes FSM and timer
//   grant_o[1:0]       : one-hot approach currently served green
//   preempt_active_o   : high outside PASS
module preempt_controller
    import traffic_pkg::*;
#(
    parameter int YELLOW_TICKS    = 2,
    parameter int ALLRED_TICKS    = 1,
    parameter int MIN_GREEN_TICKS = 4,
    parameter int TICK_W          = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] preempt_req_i,
    input  logic [6:0] lights_i,
    output logic [6:0] lights_o,
    output logic       fsm_hold_o,
    output logic [1:0] grant_o,
    output logic       preempt_active_o
);

    state_e            state_q, state_d;
    logic              tgt_q, tgt_d, clr_q, clr_d;
    logic [1:0]        pend_q, pend_d, eff;
    logic [6:0]        lights_q, lights_d;
    logic              main_busy, side_busy, tgt_in, clr_in, zero, load;
    logic [TICK_W-1:0] load_val;

    tick_counter #(.WIDTH(TICK_W)) u_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load),
        .load_value_i(load_val),
        .enable_i    (enable_i),
        .zero_o      (zero)
    );

    always_comb begin
        eff       = pend_q | preempt_req_i;
        tgt_in    = ~eff[0];
        main_busy = lights_i[YM] | lights_i[GM];
        side_busy = lights_i[YS] | lights_i[GS];
        // Main is snapshotted as the clearing approach whenever it shows G or Y.
        clr_in    = ~main_busy;
        state_d   = state_q;
        tgt_d     = tgt_q;
        clr_d     = clr_q;
        case (state_q)
            PASS: if (|eff) begin
                tgt_d   = tgt_in;
                clr_d   = clr_in;
                state_d = lights_i[tgt_in ? GS : GM] ? SERVE :
                          ((main_busy | side_busy) && clr_in != tgt_in) ? CLEAR : ALLRED;
            end
            CLEAR:   if (zero) state_d = ALLRED;
            ALLRED:  if (zero) state_d = SERVE;
            SERVE: if (zero && !preempt_req_i[tgt_q]) begin
                // Hand over straight to the other pending approach without passing through PASS.
                if (eff[~tgt_q]) begin
                    state_d = CLEAR;
                    clr_d   = tgt_q;
                    tgt_d   = ~tgt_q;
                end else begin
                    state_d = RECOVER;
                end
            end
            RECOVER: if (zero) state_d = PASS;
            default: state_d = PASS;
        endcase
        // Pending clears on SERVE entry and the served approach cannot re-pend while served.
        pend_d = pend_q | preempt_req_i;
        if (state_d == SERVE) pend_d[tgt_d] = 1'b0;
        lights_d = state_d == PASS  ? lights_i :
                   state_d == CLEAR ? show(clr_d, 1'b1) :
                   state_d == SERVE ? show(tgt_d, 1'b0) : ALL_RED;
        load     = state_d != state_q;
        load_val = state_d == CLEAR ? TICK_W'(YELLOW_TICKS) :
                   state_d == SERVE ? TICK_W'(MIN_GREEN_TICKS) :
                   state_d == PASS  ? '0 : TICK_W'(ALLRED_TICKS);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PASS;
            tgt_q    <= 1'b0;
            clr_q    <= 1'b0;
            pend_q   <= '0;
            lights_q <= ALL_RED;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            clr_q    <= clr_d;
            pend_q   <= pend_d;
            lights_q <= lights_d;
        end
    end

    assign lights_o         = lights_q;
    assign fsm_hold_o       = state_q != PASS;
    assign preempt_active_o = state_q != PASS;
    assign grant_o          = state_q == SERVE ? {tgt_q, ~tgt_q} : 2'b00;

endmodule
